ckp_signal_generator: RTL and testbench

CKP_SIGNAL_GENERATOR -- requirements
Module: ckp_signal_generator

---
 rtl/ckp_signal_generator_pkg.sv | 19 +
 rtl/ckp_signal_generator_if.sv | 28 ++
 rtl/ckp_signal_generator_phase_timer.sv | 30 +++
 rtl/ckp_signal_generator.sv | 161 ++++++++++++++++
 tb/tb_ckp_signal_generator.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ckp_signal_generator_pkg.sv
// rtl/ckp_signal_generator_pkg.sv - shared wheel constants and FSM encoding for the CKP generator
package ckp_signal_generator_pkg;

   localparam int DEF_NUM_TEETH           = 60;
   localparam int DEF_NUM_LOST_TEETH      = 2;
   localparam int DEF_PERIOD_WIDTH        = 24;
   localparam int DEF_CYCLE_COUNTER_WIDTH = 32;

   // Shortest tooth that still has one high and one low cycle.
   localparam int MIN_TOOTH_PERIOD = 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      TOOTH_HIGH = 2'd1,
      TOOTH_LOW  = 2'd2,
      GAP        = 2'd3
   } ckp_state_e;

endpackage

// File: rtl/ckp_signal_generator_if.sv
// rtl/ckp_signal_generator_if.sv - control and waveform bundle between a wheel controller and the CKP generator
interface ckp_signal_generator_if
   import ckp_signal_generator_pkg::*;
#(
   parameter int NUM_TEETH           = DEF_NUM_TEETH,
   parameter int PERIOD_WIDTH        = DEF_PERIOD_WIDTH,
   parameter int CYCLE_COUNTER_WIDTH = DEF_CYCLE_COUNTER_WIDTH
);

   logic                           enable;
   logic [PERIOD_WIDTH-1:0]        tooth_period;
   logic                           ckp;
   logic [$clog2(NUM_TEETH)-1:0]   tooth_index;
   logic                           rev_tick;
   logic [CYCLE_COUNTER_WIDTH-1:0] rev_count;
   logic                           running;

   modport master (
      output enable, tooth_period,
      input  ckp, tooth_index, rev_tick, rev_count, running
   );

   modport slave (
      input  enable, tooth_period,
      output ckp, tooth_index, rev_tick, rev_count, running
   );

endinterface

// File: rtl/ckp_signal_generator_phase_timer.sv
// rtl/ckp_signal_generator_phase_timer.sv - loadable down-counter timing one high/low/gap phase
module ckp_signal_generator_phase_timer #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   // A load of N-1 makes done assert on the Nth cycle of the phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/ckp_signal_generator.sv
// rtl/ckp_signal_generator.sv - synthetic 60-2 style crank position waveform generator
module ckp_signal_generator
   import ckp_signal_generator_pkg::*;
#(
   parameter int NUM_TEETH           = DEF_NUM_TEETH,
   parameter int NUM_LOST_TEETH      = DEF_NUM_LOST_TEETH,
   parameter int PERIOD_WIDTH        = DEF_PERIOD_WIDTH,
   parameter int CYCLE_COUNTER_WIDTH = DEF_CYCLE_COUNTER_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ckp_signal_generator_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_TEETH);
   localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_TEETH - 1);
   localparam logic [IDX_W-1:0] LAST_REAL_IDX = IDX_W'(NUM_TEETH - NUM_LOST_TEETH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
   localparam logic [PERIOD_WIDTH-1:0] P_ONE  = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] P_MIN  = PERIOD_WIDTH'(MIN_TOOTH_PERIOD);
   localparam logic [CYCLE_COUNTER_WIDTH-1:0] RC_ONE = CYCLE_COUNTER_WIDTH'(1);

   ckp_state_e                     state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [CYCLE_COUNTER_WIDTH-1:0] rc_q, rc_d;
   logic [PERIOD_WIDTH-1:0]        period_q, period_d;
   logic                           tick_q, tick_d;
   logic                           ckp_q;

   logic                    tmr_clear;
   logic                    tmr_load;
   logic [PERIOD_WIDTH-1:0] tmr_value;
   logic                    tmr_done;

   logic [PERIOD_WIDTH-1:0] p_in;
   logic [PERIOD_WIDTH-1:0] high_load;
   logic [PERIOD_WIDTH-1:0] low_load;
   logic [PERIOD_WIDTH-1:0] gap_load;
   logic                    start_high;
   logic                    wrap;

   // The incoming period is clamped here and only sampled when a tooth position begins.
   assign p_in      = (bus.tooth_period < P_MIN) ? P_MIN : bus.tooth_period;
   assign high_load = (p_in >> 1) - P_ONE;
   assign gap_load  = p_in - P_ONE;
   assign low_load  = period_q - (period_q >> 1) - P_ONE;

   ckp_signal_generator_phase_timer #(
      .WIDTH (PERIOD_WIDTH)
   ) u_phase_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (tmr_clear),
      .load       (tmr_load),
      .load_value (tmr_value),
      .done       (tmr_done)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rc_d       = rc_q;
      period_d   = period_q;
      tick_d     = 1'b0;
      tmr_clear  = 1'b0;
      tmr_load   = 1'b0;
      tmr_value  = '0;
      start_high = 1'b0;
      wrap       = 1'b0;

      if (!bus.enable) begin
         state_d   = IDLE;
         idx_d     = '0;
         tmr_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               rc_d       = '0;
               idx_d      = '0;
               start_high = 1'b1;
            end
            TOOTH_HIGH: begin
               if (tmr_done) begin
                  state_d   = TOOTH_LOW;
                  tmr_load  = 1'b1;
                  tmr_value = low_load;
               end
            end
            TOOTH_LOW: begin
               if (tmr_done) begin
                  if (idx_q == LAST_IDX) begin
                     wrap = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_ONE;
                     if (idx_q < LAST_REAL_IDX) begin
                        start_high = 1'b1;
                     end else begin
                        state_d   = GAP;
                        period_d  = p_in;
                        tmr_load  = 1'b1;
                        tmr_value = gap_load;
                     end
                  end
               end
            end
            GAP: begin
               if (tmr_done) begin
                  if (idx_q == LAST_IDX) begin
                     wrap = 1'b1;
                  end else begin
                     idx_d     = idx_q + IDX_ONE;
                     period_d  = p_in;
                     tmr_load  = 1'b1;
                     tmr_value = gap_load;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (wrap) begin
            idx_d      = '0;
            rc_d       = rc_q + RC_ONE;
            tick_d     = 1'b1;
            start_high = 1'b1;
         end

         if (start_high) begin
            state_d   = TOOTH_HIGH;
            period_d  = p_in;
            tmr_load  = 1'b1;
            tmr_value = high_load;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rc_q     <= '0;
         period_q <= '0;
         tick_q   <= 1'b0;
         ckp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rc_q     <= rc_d;
         period_q <= period_d;
         tick_q   <= tick_d;
         ckp_q    <= (state_d == TOOTH_HIGH);
      end
   end

   assign bus.ckp         = ckp_q;
   assign bus.tooth_index = idx_q;
   assign bus.rev_tick    = tick_q;
   assign bus.rev_count   = rc_q;
   assign bus.running     = (state_q != IDLE);

endmodule

// File: tb/tb_ckp_signal_generator.sv
// tb/tb_ckp_signal_generator.sv - scoreboard bench for the CKP generator
module tb_ckp_signal_generator;

   localparam int NT = 60;
   localparam int NL = 2;
   localparam int PW = 24;
   localparam int CW = 32;

   localparam int K_LOW  = 0;
   localparam int K_HIGH = 1;
   localparam int K_TICK = 2;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   ckp_signal_generator_if #(
      .NUM_TEETH           (NT),
      .PERIOD_WIDTH        (PW),
      .CYCLE_COUNTER_WIDTH (CW)
   ) bus ();

   ckp_signal_generator #(
      .NUM_TEETH           (NT),
      .NUM_LOST_TEETH      (NL),
      .PERIOD_WIDTH        (PW),
      .CYCLE_COUNTER_WIDTH (CW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int kind;
      int len;
      int idx;
   } rec_t;

   rec_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   bit   in_run  = 1'b0;
   bit   run_lvl = 1'b0;
   int   run_len = 0;
   int   run_idx = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic check_rec(input int kind, input int len, input int idx);
      rec_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_record: got kind=%0d len=%0d idx=%0d, expected none", kind, len, idx);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.len != len || e.idx != idx) begin
            n_fail++;
            $display("FAIL run_record: got kind=%0d len=%0d idx=%0d, expected kind=%0d len=%0d idx=%0d",
                     kind, len, idx, e.kind, e.len, e.idx);
         end
      end
   endtask

   task automatic push_run(input int kind, input int len, input int idx);
      rec_t e;
      e.kind = kind;
      e.len  = len;
      e.idx  = idx;
      exp_q.push_back(e);
   endtask

   task automatic push_teeth(input int first, input int last, input int hi, input int lo);
      for (int t = first; t <= last; t++) begin
         push_run(K_HIGH, hi, t);
         push_run(K_LOW, lo, t);
      end
   endtask

   // Last real tooth: its low run merges with the gap, then the wrap tick.
   task automatic push_last(input int hi, input int lo_gap, input int rev);
      push_run(K_HIGH, hi, 57);
      push_run(K_LOW, lo_gap, 57);
      push_run(K_TICK, rev, 0);
   endtask

   task automatic wait_rev(input int n, input int budget);
      int c = 0;
      while (int'(bus.rev_count) != n && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("wait_rev_count", bus.rev_count, 32'(n));
   endtask

   task automatic wait_tooth(input int idx, input logic lvl, input int budget);
      int c = 0;
      while (!(int'(bus.tooth_index) == idx && bus.ckp == lvl) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("wait_tooth_reached", 32'(c < budget), 32'd1);
   endtask

   // Monitor: turns the ckp waveform into level runs while running, plus rev_tick events.
   always @(negedge clk) begin
      if (!bus.running) begin
         in_run = 1'b0;
      end else if (!in_run) begin
         in_run  = 1'b1;
         run_lvl = bus.ckp;
         run_len = 1;
         run_idx = int'(bus.tooth_index);
      end else if (bus.ckp == run_lvl) begin
         run_len++;
      end else begin
         check_rec(int'(run_lvl), run_len, run_idx);
         run_lvl = bus.ckp;
         run_len = 1;
         run_idx = int'(bus.tooth_index);
      end
      if (bus.rev_tick) check_rec(K_TICK, int'(bus.rev_count), int'(bus.tooth_index));
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n          = 1'b0;
      bus.enable       = 1'b0;
      bus.tooth_period = PW'(10);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ckp",         32'(bus.ckp),         32'd0);
      check("reset_tooth_index", 32'(bus.tooth_index), 32'd0);
      check("reset_rev_tick",    32'(bus.rev_tick),    32'd0);
      check("reset_rev_count",   bus.rev_count,        32'd0);
      check("reset_running",     32'(bus.running),     32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Period 10: two full revolutions, then drop enable in tooth 30 high.
      for (int r = 1; r <= 2; r++) begin
         push_teeth(0, 56, 5, 5);
         push_last(5, 25, r);
      end
      push_teeth(0, 29, 5, 5);
      bus.enable = 1'b1;
      wait_rev(2, 2000);
      wait_tooth(30, 1'b1, 1000);
      bus.enable = 1'b0;
      @(posedge clk); #1;
      check("stop_ckp",         32'(bus.ckp),         32'd0);
      check("stop_tooth_index", 32'(bus.tooth_index), 32'd0);
      check("stop_running",     32'(bus.running),     32'd0);
      check("stop_rev_tick",    32'(bus.rev_tick),    32'd0);
      check("stop_rev_count",   bus.rev_count,        32'd2);
      repeat (3) @(posedge clk);
      #1;

      // Restart: 10 -> 7 during tooth 12, then clamped periods 0 and 1, reset in the gap.
      push_teeth(0, 12, 5, 5);
      push_teeth(13, 56, 3, 4);
      push_last(3, 18, 1);
      push_teeth(0, 0, 3, 4);
      push_teeth(1, 56, 1, 1);
      push_last(1, 5, 2);
      push_teeth(0, 56, 1, 1);
      push_last(1, 5, 3);
      push_teeth(0, 56, 1, 1);
      push_run(K_HIGH, 1, 57);

      bus.enable = 1'b1;
      @(posedge clk); #1;
      check("restart_rev_count",   bus.rev_count,        32'd0);
      check("restart_ckp",         32'(bus.ckp),         32'd1);
      check("restart_tooth_index", 32'(bus.tooth_index), 32'd0);

      wait_tooth(12, 1'b1, 500);
      repeat (2) @(posedge clk);
      #1;
      bus.tooth_period = PW'(7);
      wait_rev(1, 1000);
      bus.tooth_period = PW'(0);
      wait_rev(2, 500);
      bus.tooth_period = PW'(1);
      wait_rev(3, 500);
      wait_tooth(58, 1'b0, 500);

      reset_n = 1'b0;
      #2;
      check("gap_reset_ckp",         32'(bus.ckp),         32'd0);
      check("gap_reset_tooth_index", 32'(bus.tooth_index), 32'd0);
      check("gap_reset_rev_tick",    32'(bus.rev_tick),    32'd0);
      check("gap_reset_rev_count",   bus.rev_count,        32'd0);
      check("gap_reset_running",     32'(bus.running),     32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("release_ckp_low", 32'(bus.ckp), 32'd0);
      @(posedge clk); #1;
      check("release_ckp_rise",    32'(bus.ckp),         32'd1);
      check("release_tooth_index", 32'(bus.tooth_index), 32'd0);
      check("release_running",     32'(bus.running),     32'd1);
      bus.enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
